// File: rtl/sync_down_counter_if.sv
// Control/status bundle for the loadable down-counter: controller drives strobes, counter returns count and flags.
// Combinational wiring only; no flow control (every input is sampled on every clk edge).
// No backpressure: the counter accepts a load or an enable on any edge.
interface sync_down_counter_if #(
    parameter int N = 8
);
    logic         enable;
    logic         load;
    logic [N-1:0] load_val;
    logic         mode;
    logic [N-1:0] q;
    logic         tc;
    logic         busy;

    modport master (
        output enable, load, load_val, mode,
        input  q, tc, busy
    );

    modport slave (
        input  enable, load, load_val, mode,
        output q, tc, busy
    );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down-counter/interval timer with one-shot or auto-reload modes and a one-cycle terminal-count pulse.
// Latency: load and decrement take effect on the sampling edge; q, tc and busy are registered outputs.
// No backpressure: enable and load are honoured on every edge, with load taking priority over counting.
module sync_down_counter #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               reset,
    sync_down_counter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] q;
    logic [N-1:0] q_nxt;
    logic [N-1:0] reload;
    logic [N-1:0] reload_nxt;
    logic         tc;
    logic         tc_nxt;

    logic [N-1:0] borrow;
    logic [N-1:0] toggle;
    logic         count_en;
    logic         q_is_one;

    // q is never zero while running; the extra guard keeps the chain from ever wrapping to all-ones.
    assign count_en = (state == RUN) && bus.enable && (q != '0);
    assign q_is_one = (q == N'(1));

    // Borrow chain: bit i toggles only when every lower bit is already zero.
    assign borrow[0] = 1'b1;
    assign toggle[0] = count_en;

    genvar i;
    generate
        for (i = 1; i < N; i++) begin : g_borrow
            assign borrow[i] = borrow[i-1] & ~q[i-1];
            assign toggle[i] = count_en & borrow[i];
        end
    endgenerate

    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        reload_nxt = reload;
        tc_nxt     = 1'b0;

        if (bus.load) begin
            q_nxt      = bus.load_val;
            reload_nxt = bus.load_val;
            state_nxt  = (bus.load_val != '0) ? RUN : IDLE;
        end else if (count_en) begin
            if (q_is_one) begin
                tc_nxt = 1'b1;
                // mode is read live, so a change mid-count decides this terminal step
                if (bus.mode) begin
                    q_nxt = reload;
                end else begin
                    q_nxt     = q ^ toggle;
                    state_nxt = IDLE;
                end
            end else begin
                q_nxt = q ^ toggle;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            reload <= reload_nxt;
            tc     <= tc_nxt;
        end
    end

    assign bus.q    = q;
    assign bus.tc   = tc;
    assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: directed steps push hand-computed {q,tc,busy}; a monitor pops and compares.
module tb_sync_down_counter;

    localparam int N = 8;

    logic clk;
    logic reset;

    sync_down_counter_if #(.N(N)) bus ();

    sync_down_counter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N+1:0] exp_q[$];
    int           tag_q[$];
    int           n_cmp;
    int           n_err;
    int           step;
    event         chk_ev;

    // Drive one cycle of inputs away from the rising edge and queue the state expected after that edge.
    task automatic cyc(input logic rst_v, input logic en, input logic ld, input logic [N-1:0] lv,
                       input logic md, input logic [N-1:0] eq, input logic etc, input logic eb);
        @(negedge clk);
        reset        = rst_v;
        bus.enable   = en;
        bus.load     = ld;
        bus.load_val = lv;
        bus.mode     = md;
        exp_q.push_back({eq, etc, eb});
        tag_q.push_back(step);
        step++;
    endtask

    // Assert reset between edges and check outputs before the next rising edge.
    task automatic async_rst();
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.push_back({{N{1'b0}}, 1'b0, 1'b0});
        tag_q.push_back(step);
        step++;
        ->chk_ev;
    endtask

    initial begin : monitor
        logic [N+1:0] e;
        int           t;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_cmp += 3;
                if (bus.q !== e[N+1:2]) begin
                    n_err++;
                    $display("FAIL step %0d q: got %02h expected %02h", t, bus.q, e[N+1:2]);
                end
                if (bus.tc !== e[1]) begin
                    n_err++;
                    $display("FAIL step %0d tc: got %b expected %b", t, bus.tc, e[1]);
                end
                if (bus.busy !== e[0]) begin
                    n_err++;
                    $display("FAIL step %0d busy: got %b expected %b", t, bus.busy, e[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_cmp        = 0;
        n_err        = 0;
        step         = 0;
        reset        = 1'b0;
        bus.enable   = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mode     = 1'b0;

        // Reset held with clock running and enable high
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        // Released without a load: stays idle at zero
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // One-shot from 5
        cyc(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Periodic from 3 with a two-cycle stall at q=2
        cyc(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 8'd3, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1);
        // Mode switched to one-shot just before the terminal step
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Load collides with the terminal decrement
        cyc(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 8'd2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3F, 1'b0, 1'b1);

        // Load zero: idle, tc stays low
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Periodic V=1: tc stays high while enabled, drops when enable falls
        cyc(1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 8'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1);

        // Borrow propagation across many bits
        cyc(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hEF, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-count at q=0x55
        cyc(1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 8'h56, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 1'b1);
        async_rst();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
